corelet_ctrl: RTL and testbench

CORELET_CTRL -- requirements
Module: corelet_ctrl

---
 rtl/corelet_pkg.sv | 42 ++++
 rtl/corelet_ctrl_phase_counter.sv | 30 +++
 rtl/corelet_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_corelet_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/corelet_pkg.sv
// Shared encodings for the corelet controller: FSM states, instruction bit
// positions, inst_w codes and mode encoding.
package corelet_pkg;

    localparam int unsigned INST_W = 8;
    localparam int unsigned ADDR_W = 10;

    // Bit positions inside the corelet instruction word
    localparam int unsigned INST_ACC      = 7;
    localparam int unsigned INST_OFIFO_RD = 6;
    localparam int unsigned INST_IFIFO_WR = 5;
    localparam int unsigned INST_IFIFO_RD = 4;
    localparam int unsigned INST_L0_RD    = 3;
    localparam int unsigned INST_L0_WR    = 2;

    // inst_w field codes, inst[1:0]
    localparam logic [1:0] INSTW_IDLE  = 2'b00;
    localparam logic [1:0] INSTW_KLOAD = 2'b01;
    localparam logic [1:0] INSTW_EXEC  = 2'b10;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KLOAD = 3'd1,
        ST_KEXEC = 3'd2,
        ST_XLOAD = 3'd3,
        ST_XEXEC = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/corelet_ctrl_phase_counter.sv
// phase_counter: loadable down-counter used to time every controller phase.
module phase_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over decrement; the count saturates at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequences one WS or OS tile through the corelet by issuing
// instruction words, one cycle behind the FSM state.
// Optional build macro: CORELET_CTRL_ACC_EN selects the SFP accumulate path
// (inst[7]) during every WS drain cycle; when undefined inst[7] stays 0.
module corelet_ctrl
    import corelet_pkg::*;
#(
    parameter int unsigned row     = 8,
    parameter int unsigned col     = 8,
    parameter int unsigned len_nij = 36
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              mode_out,
    output logic [ADDR_W-1:0] act_addr,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(max3(row, col, len_nij) + 1);
    localparam logic [CNT_W-1:0] W_ROW = CNT_W'(row);
    localparam logic [CNT_W-1:0] W_COL = CNT_W'(col);
    localparam logic [CNT_W-1:0] W_LEN = CNT_W'(len_nij);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(1023);

    state_t            r_state;
    logic [INST_W-1:0] r_inst;
    logic              r_mode_out;
    logic [ADDR_W-1:0] r_act_addr;
    logic              r_busy;
    logic              r_done;

    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_cnt_dec;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_zero;
    logic             w_last;
    logic             w_accept;

    phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_counter (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_count    (w_cnt),
        .o_zero_c   (w_cnt_zero)
    );

    // A zero count also ends a phase so a degenerate length can never hang
    assign w_last   = (w_cnt == CNT_W'(1)) || w_cnt_zero;
    // A start arriving while done is shown is dropped
    assign w_accept = start && !r_done;

    // Phase counter control: load the next phase length on each transition
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        w_cnt_dec  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = (mode == MODE_OS) ? W_LEN : W_ROW;
                end
            end
            ST_KLOAD: begin
                if (w_last) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = W_ROW;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_KEXEC, ST_XLOAD: begin
                if (w_last) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = W_LEN;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_XEXEC: begin
                if (w_last) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = (r_mode_out == MODE_WS) ? W_LEN : W_COL;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (ofifo_valid) begin
                    if (w_last) begin
                        w_cnt_load = 1'b1;
                        w_cnt_val  = '0;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Controller FSM; every output is registered from the current state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_inst     <= '0;
            r_mode_out <= MODE_WS;
            r_act_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inst      <= '0;
            r_inst[1:0] <= INSTW_IDLE;
            r_done      <= 1'b0;
            r_busy      <= (r_state != ST_IDLE);
            if (r_inst[INST_L0_WR]) begin
                r_act_addr <= (r_act_addr == ADDR_MAX) ? '0 : r_act_addr + ADDR_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mode_out <= mode;
                        r_act_addr <= '0;
                        r_state    <= (mode == MODE_OS) ? ST_XLOAD : ST_KLOAD;
                    end
                end
                ST_KLOAD: begin
                    r_inst[INST_L0_WR] <= 1'b1;
                    if (w_last) r_state <= ST_KEXEC;
                end
                ST_KEXEC: begin
                    r_inst[INST_L0_RD] <= 1'b1;
                    r_inst[1:0]        <= INSTW_KLOAD;
                    if (w_last) r_state <= ST_XLOAD;
                end
                ST_XLOAD: begin
                    r_inst[INST_L0_WR]    <= 1'b1;
                    r_inst[INST_IFIFO_WR] <= (r_mode_out == MODE_OS);
                    if (w_last) r_state <= ST_XEXEC;
                end
                ST_XEXEC: begin
                    r_inst[INST_L0_RD]    <= 1'b1;
                    r_inst[INST_IFIFO_RD] <= (r_mode_out == MODE_OS);
                    r_inst[1:0]           <= INSTW_EXEC;
                    if (w_last) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    r_inst[INST_OFIFO_RD] <= ofifo_valid;
`ifdef CORELET_CTRL_ACC_EN
                    r_inst[INST_ACC] <= (r_mode_out == MODE_WS);
`else
                    r_inst[INST_ACC] <= 1'b0;
`endif
                    if (ofifo_valid && w_last) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign inst     = r_inst;
    assign mode_out = r_mode_out;
    assign act_addr = r_act_addr;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Testbench for corelet_ctrl: table of whole-tile vectors checked cycle by
// cycle, plus hand sequences for start spam and mid-tile reset.
// Honours CORELET_CTRL_ACC_EN in the same way as the design build.
module tb_corelet_ctrl;

`ifdef CORELET_CTRL_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       ofifo_valid = 1'b0;
    logic [7:0] inst;
    logic       mode_out;
    logic [9:0] act_addr;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    corelet_ctrl #(
        .row     (8),
        .col     (8),
        .len_nij (36)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .mode_out    (mode_out),
        .act_addr    (act_addr),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // One tile: mode, repeating 4-cycle ofifo_valid pattern in drain (msb
    // first), edge of the done pulse counting the start edge as 1, reads,
    // final act_addr.
    typedef struct {
        logic       mode;
        logic [3:0] pat;
        int         done_edge;
        int         reads;
        int         addr_end;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {11'd0, inst, done, busy, mode_out, act_addr};
    endfunction

    // Expected instruction word before drain, j = 0 is the first active cycle
    function automatic logic [7:0] exp_pre(input logic m, input int j);
        if (!m) begin
            if (j < 8)  return 8'h04;
            if (j < 16) return 8'h09;
            if (j < 52) return 8'h04;
            return 8'h0A;
        end
        if (j < 36) return 8'h24;
        return 8'h1A;
    endfunction

    task automatic run_tile(input int i, input bit spam);
        vec_t       v;
        int         pre;
        int         nwr;
        int         reads;
        logic       vk;
        logic [7:0] ei;
        logic [7:0] acc;
        logic       ed;
        logic       eb;
        v     = vecs[i];
        pre   = v.mode ? 72 : 88;
        nwr   = 0;
        reads = 0;
        acc   = (ACC && !v.mode) ? 8'h80 : 8'h00;
        mode  = v.mode;
        start = 1'b1;
        ofifo_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = ~v.mode;
        for (int k = 1; k <= v.done_edge + 2; k++) begin
            vk = 1'b1;
            if (k > 1) begin
                if (k >= pre + 2 && k < v.done_edge)
                    vk = v.pat[3 - ((k - pre - 2) % 4)];
                ofifo_valid = vk;
                start = spam && (k == 5 || k == 100 || k == v.done_edge + 1);
                mode  = ~v.mode;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            ed = 1'b0;
            eb = 1'b1;
            if (k == 1) begin
                ei = 8'h00;
                eb = 1'b0;
            end else if (k <= pre + 1) begin
                ei = exp_pre(v.mode, k - 2);
            end else if (k < v.done_edge) begin
                ei = (vk ? 8'h40 : 8'h00) | acc;
            end else if (k == v.done_edge) begin
                ei = 8'h00;
                ed = 1'b1;
            end else begin
                ei = 8'h00;
                eb = 1'b0;
            end
            check($sformatf("v%0d_s%0d_k%0d", i, spam, k), obs(),
                  {11'd0, ei, ed, eb, v.mode, 10'(nwr)});
            if (ei[2]) nwr++;
            if (inst[6]) reads++;
        end
        ofifo_valid = 1'b0;
        check($sformatf("v%0d_reads", i), 32'(reads), 32'(v.reads));
        check($sformatf("v%0d_addr_end", i), 32'(act_addr), 32'(v.addr_end));
    endtask

    initial begin
        vecs[0] = '{1'b0, 4'b1111, 126, 36, 44};
        vecs[1] = '{1'b1, 4'b1111,  82,  8, 36};
        vecs[2] = '{1'b0, 4'b1001, 162, 36, 44};
        vecs[3] = '{1'b1, 4'b1001,  90,  8, 36};
        vecs[4] = '{1'b0, 4'b0110, 161, 36, 44};

        // Asynchronous reset before any clock edge
        #1 reset = 1'b0;
        #1;
        check("reset_no_clk", obs(), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", obs(), 32'd0);

        for (int i = 0; i < 5; i++) run_tile(i, 1'b0);

        // Extra start pulses while busy and during the done cycle
        run_tile(0, 1'b1);

        // Reset in the middle of an OS XEXEC phase
        mode  = 1'b1;
        start = 1'b1;
        ofifo_valid = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        check("os_xexec_pre_reset", obs(), {11'd0, 8'h1A, 1'b0, 1'b1, 1'b1, 10'd36});
        #2 reset = 1'b0;
        #1;
        check("reset_mid_xexec", obs(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", obs(), 32'd0);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_resume_after_reset", obs(), 32'd0);
        run_tile(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
